// File: rtl/nasti_lite_mem_reader.sv
// NASTI-lite read slave: single-beat AR requests become word reads on a fixed-latency
// memory port; R beats return in acceptance order through a small response FIFO.
module nasti_lite_mem_reader #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MEM_SIZE   = 256,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic [ID_WIDTH-1:0]                           lite_ar_id,
    input  logic [ADDR_WIDTH-1:0]                         lite_ar_addr,
    input  logic [2:0]                                    lite_ar_prot,
    input  logic [3:0]                                    lite_ar_qos,
    input  logic [3:0]                                    lite_ar_region,
    input  logic [USER_WIDTH-1:0]                         lite_ar_user,
    input  logic                                          lite_ar_valid,
    output logic                                          lite_ar_ready,
    output logic [ID_WIDTH-1:0]                           lite_r_id,
    output logic [DATA_WIDTH-1:0]                         lite_r_data,
    output logic [1:0]                                    lite_r_resp,
    output logic [USER_WIDTH-1:0]                         lite_r_user,
    output logic                                          lite_r_valid,
    input  logic                                          lite_r_ready,
    output logic                                          mem_req,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]                         mem_rdata,
    input  logic                                          mem_err
);

    localparam int WSHIFT = $clog2(DATA_WIDTH / 8);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $fatal(1, "nasti_lite_mem_reader: DATA_WIDTH must be 32 or 64");
    end
    if (USER_WIDTH < 1 || RD_LATENCY < 1 || FIFO_DEPTH < 1) begin : g_bad_sizes
        $fatal(1, "nasti_lite_mem_reader: USER_WIDTH, RD_LATENCY, FIFO_DEPTH must be >= 1");
    end
    if (MEM_SIZE < 1 || (MEM_SIZE & (MEM_SIZE - 1)) != 0
        || 64'(MEM_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_bad_mem_size
        $fatal(1, "nasti_lite_mem_reader: MEM_SIZE must be a power of two <= 2**ADDR_WIDTH");
    end

    logic [CW-1:0] outst_q, outst_d, count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          accept, in_range, push, pop;

    logic [RD_LATENCY-1:0]                 pipe_valid_q, pipe_valid_d;
    logic [RD_LATENCY-1:0]                 pipe_decerr_q, pipe_decerr_d;
    logic [RD_LATENCY-1:0][ID_WIDTH-1:0]   pipe_id_q, pipe_id_d;
    logic [RD_LATENCY-1:0][USER_WIDTH-1:0] pipe_user_q, pipe_user_d;

    logic [ID_WIDTH-1:0]   push_id;
    logic [USER_WIDTH-1:0] push_user;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            push_resp;

    logic [ID_WIDTH-1:0]   fifo_id_q   [FIFO_DEPTH];
    logic [USER_WIDTH-1:0] fifo_user_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [1:0]            fifo_resp_q [FIFO_DEPTH];

    logic unused_ok;
    assign unused_ok = ^{lite_ar_prot, lite_ar_qos, lite_ar_region};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Handshakes and bookkeeping; ready depends only on the registered outstanding count.
    always_comb begin
        lite_ar_ready = rstn && (outst_q < DEPTH_C);
        lite_r_valid  = rstn && (count_q != '0);
        lite_r_id     = fifo_id_q[rd_ptr_q];
        lite_r_user   = fifo_user_q[rd_ptr_q];
        lite_r_data   = fifo_data_q[rd_ptr_q];
        lite_r_resp   = fifo_resp_q[rd_ptr_q];

        in_range = 64'(lite_ar_addr) < 64'(MEM_SIZE);
        accept   = lite_ar_valid && lite_ar_ready;
        pop      = lite_r_valid && lite_r_ready;
        push     = pipe_valid_q[RD_LATENCY-1];
        mem_req  = accept && in_range;
        mem_addr = lite_ar_addr[ADDR_WIDTH-1:WSHIFT];

        outst_d  = outst_q + CW'(accept) - CW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Side pipeline tracks each read until its memory data arrives.
    always_comb begin
        pipe_valid_d     = pipe_valid_q;
        pipe_decerr_d    = pipe_decerr_q;
        pipe_id_d        = pipe_id_q;
        pipe_user_d      = pipe_user_q;
        pipe_valid_d[0]  = accept;
        pipe_decerr_d[0] = !in_range;
        pipe_id_d[0]     = lite_ar_id;
        pipe_user_d[0]   = lite_ar_user;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_d[i]  = pipe_valid_q[i-1];
            pipe_decerr_d[i] = pipe_decerr_q[i-1];
            pipe_id_d[i]     = pipe_id_q[i-1];
            pipe_user_d[i]   = pipe_user_q[i-1];
        end
    end

    always_comb begin
        push_id   = pipe_id_q[RD_LATENCY-1];
        push_user = pipe_user_q[RD_LATENCY-1];
        if (pipe_decerr_q[RD_LATENCY-1]) begin
            push_data = '0;
            push_resp = 2'b11;
        end else begin
            push_data = mem_rdata;
            push_resp = mem_err ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            outst_q       <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pipe_valid_q  <= '0;
            pipe_decerr_q <= '0;
            pipe_id_q     <= '0;
            pipe_user_q   <= '0;
        end else begin
            outst_q       <= outst_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_decerr_q <= pipe_decerr_d;
            pipe_id_q     <= pipe_id_d;
            pipe_user_q   <= pipe_user_d;
        end
    end

    // Push never finds the FIFO full: outst caps total in flight at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_id_q[i]   <= '0;
                fifo_user_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_resp_q[i] <= '0;
            end
        end else if (push) begin
            fifo_id_q[wr_ptr_q]   <= push_id;
            fifo_user_q[wr_ptr_q] <= push_user;
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_resp_q[wr_ptr_q] <= push_resp;
        end
    end

endmodule

// File: tb/tb_nasti_lite_mem_reader.sv
// Directed bench for nasti_lite_mem_reader with a 1-cycle memory model (ADDR_WIDTH 9, MEM_SIZE 256).
module tb_nasti_lite_mem_reader;

    localparam int AW = 9;
    localparam int MA = 7;

    typedef struct packed {
        logic [0:0]  id;
        logic [0:0]  user;
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [0:0]    ar_id;
    logic [AW-1:0] ar_addr;
    logic [2:0]    ar_prot;
    logic [3:0]    ar_qos, ar_region;
    logic [0:0]    ar_user;
    logic          ar_valid, ar_ready;
    logic [0:0]    r_id, r_user;
    logic [31:0]   r_data;
    logic [1:0]    r_resp;
    logic          r_valid, r_ready;
    logic          mem_req, mem_err;
    logic [MA-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0]   tbmem [128];
    logic          err_en;
    logic [MA-1:0] err_word;
    logic [AW-1:0] req_addr [16];
    logic [0:0]    req_id   [16];
    logic [0:0]    req_user [16];
    beat_t         exp_q [$];

    nasti_lite_mem_reader #(
        .ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .USER_WIDTH(1),
        .MEM_SIZE(256), .RD_LATENCY(1), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .lite_ar_id(ar_id), .lite_ar_addr(ar_addr), .lite_ar_prot(ar_prot),
        .lite_ar_qos(ar_qos), .lite_ar_region(ar_region), .lite_ar_user(ar_user),
        .lite_ar_valid(ar_valid), .lite_ar_ready(ar_ready),
        .lite_r_id(r_id), .lite_r_data(r_data), .lite_r_resp(r_resp), .lite_r_user(r_user),
        .lite_r_valid(r_valid), .lite_r_ready(r_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Memory model: data one cycle after mem_req; junk (and err) when not requested.
    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= tbmem[mem_addr];
            mem_err   <= err_en && (mem_addr == err_word);
        end else begin
            mem_rdata <= 32'hBAD0BAD0;
            mem_err   <= 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic beat_t model(input logic [AW-1:0] a, input logic [0:0] id, input logic [0:0] u);
        beat_t b;
        b.id   = id;
        b.user = u;
        if (int'(a) >= 256) begin
            b.data = 32'h0;
            b.resp = 2'b11;
        end else begin
            b.data = tbmem[a[AW-1:2]];
            b.resp = (err_en && (a[AW-1:2] == err_word)) ? 2'b10 : 2'b00;
        end
        return b;
    endfunction

    // Issues n requests from req_* holding ar_valid; r_ready assumed high.
    // pat enables the exact ready/valid cadence check for FIFO_DEPTH 2, RD_LATENCY 1.
    task automatic burst(input int n, input bit pat);
        int    issued = 0;
        int    got = 0;
        int    c = 0;
        beat_t e;
        exp_q.delete();
        while ((issued < n || got < n) && c < 100) begin
            ar_valid = (issued < n);
            ar_addr  = req_addr[issued % 16];
            ar_id    = req_id[issued % 16];
            ar_user  = req_user[issued % 16];
            #1;
            if (pat) begin
                chk("cadence_r_valid", r_valid, (c >= 2) && (c % 3 != 1));
                if (issued < n) chk("cadence_ar_ready", ar_ready, (c % 3 != 2));
            end
            if (r_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", r_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    $display("R beat %0d: id=%0d user=%0d data=%08h resp=%0d", got, r_id, r_user, r_data, r_resp);
                    chk("beat_data", r_data, e.data);
                    chk("beat_resp", r_resp, e.resp);
                    chk("beat_id", r_id, e.id);
                    chk("beat_user", r_user, e.user);
                end
                got++;
            end
            if (ar_valid && ar_ready) begin
                chk("accept_mem_req", mem_req, int'(ar_addr) < 256);
                if (int'(ar_addr) < 256) chk("accept_mem_addr", mem_addr, ar_addr >> 2);
                exp_q.push_back(model(ar_addr, ar_id, ar_user));
                issued++;
            end
            tick();
            c++;
        end
        ar_valid = 1'b0;
        chk("burst_beats", got, n);
        chk("burst_leftover", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) tbmem[i] = 32'hA5000000 + i * 32'h00010101;
        tbmem[4] = 32'hDEADBEEF;
        tbmem[8] = 32'h00001234;
        err_en    = 1'b0;
        err_word  = '0;
        ar_prot   = 3'd5;
        ar_qos    = 4'hA;
        ar_region = 4'h3;

        // Reset with a request pending: nothing may be accepted or requested.
        rstn = 1'b0; ar_valid = 1'b1; ar_addr = 9'h010; ar_id = 1'b1; ar_user = 1'b1; r_ready = 1'b0;
        tick();
        #1;
        chk("rst_ar_ready", ar_ready, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_id", r_id, 1'b0);
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_r_resp", r_resp, 2'b00);
        chk("rst_r_user", r_user, 1'b0);
        tick();
        rstn = 1'b1; ar_valid = 1'b0;
        #1;
        chk("post_rst_ar_ready", ar_ready, 1'b1);
        chk("post_rst_r_valid", r_valid, 1'b0);
        tick();

        // Single read: latency AR(t) -> R valid(t+2).
        r_ready = 1'b1;
        ar_valid = 1'b1; ar_addr = 9'h010; ar_id = 1'b1; ar_user = 1'b0;
        #1;
        chk("single_ar_ready", ar_ready, 1'b1);
        chk("single_mem_req", mem_req, 1'b1);
        chk("single_mem_addr", mem_addr, 7'h04);
        tick();
        ar_valid = 1'b0;
        #1;
        chk("single_r_valid_t1", r_valid, 1'b0);
        tick();
        #1;
        chk("single_r_valid_t2", r_valid, 1'b1);
        chk("single_r_data", r_data, 32'hDEADBEEF);
        chk("single_r_resp", r_resp, 2'b00);
        chk("single_r_id", r_id, 1'b1);
        $display("R beat single: id=%0d data=%08h resp=%0d", r_id, r_data, r_resp);
        tick();
        #1;
        chk("single_r_valid_t3", r_valid, 1'b0);
        tick();

        // Back-to-back: 8 reads 0x00..0x1C; 2 per 3 cycles with depth 2, latency 1.
        for (int i = 0; i < 8; i++) begin
            req_addr[i] = AW'(i * 4);
            req_id[i]   = 1'(i);
            req_user[i] = 1'(i >> 1);
        end
        burst(8, 1'b1);

        // Backpressure: third request waits until a pop frees a slot.
        r_ready = 1'b0;
        ar_valid = 1'b1; ar_addr = 9'h008; ar_id = 1'b0; ar_user = 1'b0;
        #1;
        chk("bp_ready_a", ar_ready, 1'b1);
        tick();
        ar_addr = 9'h00C; ar_id = 1'b1; ar_user = 1'b1;
        #1;
        chk("bp_ready_b", ar_ready, 1'b1);
        tick();
        ar_addr = 9'h014; ar_id = 1'b0; ar_user = 1'b0;
        #1;
        chk("bp_ready_full", ar_ready, 1'b0);
        chk("bp_head_valid", r_valid, 1'b1);
        chk("bp_head_data", r_data, tbmem[2]);
        tick();
        r_ready = 1'b1;
        #1;
        chk("bp_ready_pop_cycle", ar_ready, 1'b0);
        chk("bp_head_stable", r_data, tbmem[2]);
        tick();
        r_ready = 1'b0;
        #1;
        chk("bp_ready_after_pop", ar_ready, 1'b1);
        chk("bp_head2_data", r_data, tbmem[3]);
        chk("bp_head2_id", r_id, 1'b1);
        chk("bp_head2_user", r_user, 1'b1);
        tick();
        ar_valid = 1'b0;
        #1;
        chk("bp_ready_full2", ar_ready, 1'b0);
        tick();
        r_ready = 1'b1;
        #1;
        chk("bp_drain1_data", r_data, tbmem[3]);
        tick();
        #1;
        chk("bp_drain2_valid", r_valid, 1'b1);
        chk("bp_drain2_data", r_data, tbmem[5]);
        chk("bp_drain2_id", r_id, 1'b0);
        tick();
        #1;
        chk("bp_empty", r_valid, 1'b0);
        tick();

        // Decode errors interleaved with good reads; order must hold.
        req_addr[0] = 9'h018; req_id[0] = 1'b1; req_user[0] = 1'b0;
        req_addr[1] = 9'h100; req_id[1] = 1'b0; req_user[1] = 1'b1;
        req_addr[2] = 9'h024; req_id[2] = 1'b1; req_user[2] = 1'b1;
        req_addr[3] = 9'h1FC; req_id[3] = 1'b0; req_user[3] = 1'b0;
        req_addr[4] = 9'h101; req_id[4] = 1'b1; req_user[4] = 1'b0;
        req_addr[5] = 9'h0FF; req_id[5] = 1'b0; req_user[5] = 1'b1;
        burst(6, 1'b0);

        // Slave error from memory.
        err_en = 1'b1; err_word = 7'd8;
        req_addr[0] = 9'h020; req_id[0] = 1'b1; req_user[0] = 1'b1;
        burst(1, 1'b0);
        err_en = 1'b0;

        // Reset mid-flight: two reads queued, then discarded.
        r_ready = 1'b0;
        ar_valid = 1'b1; ar_addr = 9'h000; ar_id = 1'b1; ar_user = 1'b1;
        #1;
        chk("mid_ready_a", ar_ready, 1'b1);
        tick();
        ar_addr = 9'h004; ar_id = 1'b0;
        #1;
        chk("mid_ready_b", ar_ready, 1'b1);
        tick();
        ar_addr = 9'h008; rstn = 1'b0;
        #1;
        chk("mid_rst_ready", ar_ready, 1'b0);
        chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_r_valid", r_valid, 1'b0);
        tick();
        rstn = 1'b1; ar_valid = 1'b0; r_ready = 1'b1;
        #1;
        chk("mid_post_ready", ar_ready, 1'b1);
        chk("mid_post_r_data", r_data, 32'h0);
        chk("mid_post_r_id", r_id, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_no_stale_beat", r_valid, 1'b0);
            tick();
            #1;
        end
        tick();
        req_addr[0] = 9'h00C; req_id[0] = 1'b0; req_user[0] = 1'b1;
        burst(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
